// File: rtl/adc_sample_scheduler_if.sv
// Requester/ADC-controller bundle for adc_sample_scheduler.
// slave is the scheduler's view; master is the requester/ADC side.
interface adc_sample_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int CH_W    = 3,
  parameter int DATA_W  = 12
);
  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ*CH_W-1:0] req_ch;
  logic [NUM_REQ-1:0]      gnt;
  logic [NUM_REQ-1:0]      rsp_valid;
  logic [DATA_W-1:0]       rsp_data;
  logic                    rsp_err;
  logic                    adc_tick;
  logic                    adc_start;
  logic [CH_W-1:0]         adc_ch;
  logic                    adc_done;
  logic [DATA_W-1:0]       adc_data;
  logic                    busy;

  modport slave (
    input  req, req_ch, adc_done, adc_data,
    output gnt, rsp_valid, rsp_data, rsp_err, adc_tick, adc_start, adc_ch, busy
  );

  modport master (
    output req, req_ch, adc_done, adc_data,
    input  gnt, rsp_valid, rsp_data, rsp_err, adc_tick, adc_start, adc_ch, busy
  );
endinterface

// File: rtl/adc_sample_scheduler.sv
// Round-robin ADC conversion scheduler driven by a free-running DIV-cycle
// clock-enable tick; returns each result or a timeout error to the winner.
module adc_sample_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int CH_W          = 3,
  parameter int DATA_W        = 12,
  parameter int DIV           = 16,
  parameter int TIMEOUT_TICKS = 64
) (
  input  logic                    clk_50M,
  input  logic                    rst_n,
  adc_sample_scheduler_if.slave   bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(DIV);
  localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_tick;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    r_win;
  logic [TO_W-1:0]     r_tcnt;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [NUM_REQ-1:0]  r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_rsp_err;
  logic                r_adc_start;
  logic [CH_W-1:0]     r_adc_ch;
  logic                r_busy;

  logic                w_found;
  logic [IDX_W-1:0]    w_win;
  logic [IDX_W-1:0]    w_cand;
  logic [CH_W-1:0]     w_ch;
  logic [NUM_REQ-1:0]  w_win_onehot;
  logic [NUM_REQ-1:0]  w_rsp_onehot;

  // Search ptr+1, ptr+2, ... wrapping; first requester found wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      w_cand = IDX_W'((32'(r_ptr) + i) % 32'(NUM_REQ));
      if (!w_found && bus.req[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  always_comb begin
    w_ch = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_win == IDX_W'(i)) w_ch = bus.req_ch[i*CH_W +: CH_W];
    end
  end

  assign w_win_onehot = NUM_REQ'(1) << w_win;
  assign w_rsp_onehot = NUM_REQ'(1) << r_win;

  // r_tick is registered one cycle early so it is high exactly while r_cnt == DIV-1.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_tick      <= 1'b0;
      r_ptr       <= IDX_W'(NUM_REQ - 1);
      r_win       <= '0;
      r_tcnt      <= '0;
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_adc_start <= 1'b0;
      r_adc_ch    <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_cnt       <= (r_cnt == CNT_W'(DIV - 1)) ? '0 : r_cnt + CNT_W'(1);
      r_tick      <= (r_cnt == CNT_W'(DIV - 2));
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      case (r_state)
        S_IDLE: begin
          if (r_tick && w_found) begin
            r_win       <= w_win;
            r_gnt       <= w_win_onehot;
            r_adc_start <= 1'b1;
            r_adc_ch    <= w_ch;
            r_busy      <= 1'b1;
            r_state     <= S_START;
          end
        end
        S_START: begin
          if (r_tick) begin
            r_adc_start <= 1'b0;
            r_tcnt      <= '0;
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_tick) begin
            if (bus.adc_done) begin
              r_rsp_valid <= w_rsp_onehot;
              r_rsp_data  <= bus.adc_data;
              r_rsp_err   <= 1'b0;
              r_busy      <= 1'b0;
              r_ptr       <= r_win;
              r_state     <= S_IDLE;
            end else begin
              r_tcnt <= r_tcnt + TO_W'(1);
              if (r_tcnt == TO_W'(TIMEOUT_TICKS - 1)) begin
                r_rsp_valid <= w_rsp_onehot;
                r_rsp_data  <= '0;
                r_rsp_err   <= 1'b1;
                r_busy      <= 1'b0;
                r_ptr       <= r_win;
                r_state     <= S_IDLE;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.adc_tick  = r_tick;
  assign bus.adc_start = r_adc_start;
  assign bus.adc_ch    = r_adc_ch;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Scoreboard bench for adc_sample_scheduler: a tick-level transaction model
// drives requesters and the ADC stub and queues expected grants/responses.
module tb_adc_sample_scheduler;
  localparam int NUM_REQ = 4;
  localparam int CH_W    = 3;
  localparam int DATA_W  = 12;
  localparam int DIV     = 16;
  localparam int TO      = 64;

  logic clk_50M = 1'b0;
  logic rst_n   = 1'b0;
  always #10 clk_50M = ~clk_50M;

  adc_sample_scheduler_if #(.NUM_REQ(NUM_REQ), .CH_W(CH_W), .DATA_W(DATA_W)) bus ();

  adc_sample_scheduler #(
    .NUM_REQ(NUM_REQ), .CH_W(CH_W), .DATA_W(DATA_W), .DIV(DIV), .TIMEOUT_TICKS(TO)
  ) dut (
    .clk_50M(clk_50M),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  typedef struct { int idx; logic [CH_W-1:0] ch; int cyc; int start_off; } gnt_t;
  typedef struct { int idx; logic [DATA_W-1:0] data; logic err; int cyc; } rsp_t;

  gnt_t gq[$];
  rsp_t rq[$];
  int   obs_order[$];

  int n_checks = 0;
  int n_pass   = 0;
  int n_rsp    = 0;
  int cyc      = 0;

  // stimulus knobs set by the main sequence
  logic [NUM_REQ-1:0] req_allow = '0;
  int                 req_prob  = 100;
  int                 drop_prob = 0;
  int                 plan_mode = 1;
  bit                 fix_ch    = 1'b0;
  logic [CH_W-1:0]    ch_val    = '0;

  // model state
  logic [NUM_REQ-1:0] m_req = '0;
  bit                 m_out = 1'b0;
  int                 m_w   = 0;
  int                 m_arb = 0;
  int                 m_n   = 0;
  int                 m_ptr = NUM_REQ - 1;

  always @(posedge clk_50M) cyc <= rst_n ? cyc + 1 : 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
    for (int i = 0; i < NUM_REQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int order_at(input int i);
    if (i < obs_order.size()) return obs_order[i];
    return -1;
  endfunction

  // Number of the WAIT tick on which adc_done is raised; 0 means never (timeout).
  function automatic int pick_plan(input int w);
    int r;
    r = $urandom_range(0, 19);
    case (plan_mode)
      1: return 1;
      2: return 0;
      3: return TO;
      4: return 3;
      5: return (w == 3) ? 0 : 1;
      default: begin
        if (r == 0) return 0;
        if (r == 1) return TO;
        return $urandom_range(1, 6);
      end
    endcase
  endfunction

  // Model + stimulus: in tick terms, grant at arbitration tick A, START tick A+DIV,
  // WAIT tick k at A+DIV*(1+k); every DUT output appears one cycle after its tick.
  initial begin : model
    int   c;
    bit   tick;
    bit   done;
    int   w;
    int   cand;
    int   fin;
    gnt_t g;
    rsp_t r;
    bus.req = '0; bus.req_ch = '0; bus.adc_done = 1'b0; bus.adc_data = '0;
    forever begin
      @(negedge clk_50M);
      if (!rst_n) begin
        m_out = 1'b0;
        m_ptr = NUM_REQ - 1;
        gq.delete();
        rq.delete();
        continue;
      end
      c    = cyc;
      tick = ((c % DIV) == DIV - 1);
      for (int i = 0; i < NUM_REQ; i++)
        if (!m_req[i] && req_allow[i] && !(m_out && m_w == i) && $urandom_range(0, 99) < req_prob)
          m_req[i] = 1'b1;
      if (m_out && m_req[m_w] && $urandom_range(0, 99) < drop_prob) m_req[m_w] = 1'b0;
      bus.req = m_req;
      for (int i = 0; i < NUM_REQ; i++)
        bus.req_ch[i*CH_W +: CH_W] = fix_ch ? ch_val : CH_W'($urandom);
      bus.adc_data = DATA_W'($urandom);
      done = ($urandom_range(0, 1) == 1);
      if (tick && m_out && c > m_arb + DIV) done = (m_n != 0 && c == m_arb + DIV * (1 + m_n));
      bus.adc_done = done;
      if (tick) begin
        if (m_out) begin
          fin = m_arb + DIV * (1 + ((m_n != 0) ? m_n : TO));
          if (c == fin) begin
            r.idx  = m_w;
            r.data = (m_n != 0) ? bus.adc_data : '0;
            r.err  = (m_n == 0);
            r.cyc  = c + 1;
            rq.push_back(r);
            m_ptr = m_w;
            m_out = 1'b0;
            m_req[m_w] = 1'b0;
          end
        end else if (m_req != '0) begin
          w = -1;
          for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (m_ptr + k) % NUM_REQ;
            if (w < 0 && m_req[cand]) w = cand;
          end
          m_out = 1'b1;
          m_w   = w;
          m_arb = c;
          m_n   = pick_plan(w);
          g.idx       = w;
          g.ch        = bus.req_ch[w*CH_W +: CH_W];
          g.cyc       = c + 1;
          g.start_off = c + DIV + 1;
          gq.push_back(g);
        end
      end
    end
  end

  initial begin : monitor
    int   c;
    int   start_off;
    gnt_t g;
    rsp_t r;
    start_off = -1;
    forever begin
      @(negedge clk_50M);
      if (!rst_n) begin
        start_off = -1;
        continue;
      end
      c = cyc;
      chk("adc_tick", 32'(bus.adc_tick), 32'((c % DIV) == DIV - 1));
      if (bus.gnt != '0 || (gq.size() != 0 && gq[0].cyc <= c)) begin
        if (gq.size() == 0) chk("gnt_unexpected", 32'(bus.gnt), 0);
        else begin
          g = gq.pop_front();
          chk("gnt_vec", 32'(bus.gnt), 32'(1) << g.idx);
          chk("gnt_cycle", c, g.cyc);
          chk("adc_ch", 32'(bus.adc_ch), 32'(g.ch));
          chk("start_at_gnt", 32'(bus.adc_start), 1);
          chk("busy_at_gnt", 32'(bus.busy), 1);
          start_off = g.start_off;
          obs_order.push_back(onehot_idx(bus.gnt));
        end
      end
      if (start_off >= 0) begin
        if (c == start_off - 1) chk("start_last_cycle", 32'(bus.adc_start), 1);
        else if (c == start_off) begin
          chk("start_drop", 32'(bus.adc_start), 0);
          start_off = -1;
        end
      end
      if (bus.rsp_valid != '0 || (rq.size() != 0 && rq[0].cyc <= c)) begin
        if (rq.size() == 0) chk("rsp_unexpected", 32'(bus.rsp_valid), 0);
        else begin
          r = rq.pop_front();
          chk("rsp_vec", 32'(bus.rsp_valid), 32'(1) << r.idx);
          chk("rsp_cycle", c, r.cyc);
          chk("rsp_data", 32'(bus.rsp_data), 32'(r.data));
          chk("rsp_err", 32'(bus.rsp_err), 32'(r.err));
          chk("busy_at_rsp", 32'(bus.busy), 0);
          n_rsp++;
        end
      end
    end
  end

  task automatic wait_rsp(input string name, input int target, input int bound);
    int k = 0;
    while (n_rsp < target && k < bound) begin
      @(negedge clk_50M);
      k++;
    end
    chk(name, 32'(n_rsp >= target), 1);
  endtask

  task automatic drain(input string name);
    int k = 0;
    req_allow = '0;
    plan_mode = 1;
    while (!(m_req == '0 && !m_out && gq.size() == 0 && rq.size() == 0) && k < 6000) begin
      @(negedge clk_50M);
      k++;
    end
    chk(name, 32'(m_req == '0 && !m_out && gq.size() == 0 && rq.size() == 0), 1);
    repeat (2) @(negedge clk_50M);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk_50M);
    rst_n = 1'b1;
  endtask

  task automatic chk_outputs_zero(input string pfx);
    chk({pfx, "_gnt"}, 32'(bus.gnt), 0);
    chk({pfx, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
    chk({pfx, "_rsp_data"}, 32'(bus.rsp_data), 0);
    chk({pfx, "_rsp_err"}, 32'(bus.rsp_err), 0);
    chk({pfx, "_adc_tick"}, 32'(bus.adc_tick), 0);
    chk({pfx, "_adc_start"}, 32'(bus.adc_start), 0);
    chk({pfx, "_adc_ch"}, 32'(bus.adc_ch), 0);
    chk({pfx, "_busy"}, 32'(bus.busy), 0);
  endtask

  initial begin : main
    int k;
    repeat (3) @(negedge clk_50M);
    chk_outputs_zero("reset");
    rst_n = 1'b1;

    // idle: monitor checks tick positions 15, 31, 47, 63
    repeat (64) @(negedge clk_50M);
    chk("idle_start", 32'(bus.adc_start), 0);
    chk("idle_busy", 32'(bus.busy), 0);

    // single requester 1, channel 5, done on third WAIT tick
    obs_order.delete();
    fix_ch = 1'b1; ch_val = 3'd5; plan_mode = 4; req_prob = 100; req_allow = 4'b0010;
    wait_rsp("t2_response", n_rsp + 1, 2000);
    drain("t2_drain");
    chk("t2_first_gnt", 32'(order_at(0)), 1);
    fix_ch = 1'b0;

    // all requesters held, done on first WAIT tick: strict round-robin from reset
    do_reset();
    obs_order.delete();
    plan_mode = 1; req_allow = 4'b1111;
    wait_rsp("rr_responses", n_rsp + 6, 3000);
    drain("rr_drain");
    for (int i = 0; i < 6; i++) chk("rr_order", 32'(order_at(i)), 32'(i % NUM_REQ));

    // timeout on requester 2
    plan_mode = 2; req_allow = 4'b0100;
    wait_rsp("timeout_response", n_rsp + 1, 2500);
    drain("timeout_drain");

    // done coinciding with the final timeout tick
    plan_mode = 3; req_allow = 4'b0001;
    wait_rsp("lastick_response", n_rsp + 1, 2500);
    drain("lastick_drain");

    // randomized traffic with drops and mixed done/timeout plans
    plan_mode = 0; req_prob = 25; drop_prob = 3; req_allow = 4'b1111;
    wait_rsp("random_responses", n_rsp + 40, 40000);
    drain("random_drain");
    drop_prob = 0; req_prob = 100;

    // asynchronous reset while requester 3 sits in WAIT
    plan_mode = 5; req_allow = 4'b1111;
    k = 0;
    while (!(m_out && m_w == 3 && cyc > m_arb + 3 * DIV) && k < 3000) begin
      @(negedge clk_50M);
      k++;
    end
    chk("reach_wait_req3", 32'(m_out && m_w == 3 && cyc > m_arb + 3 * DIV), 1);
    @(posedge clk_50M);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_start", 32'(bus.adc_start), 0);
    chk("async_rst_busy", 32'(bus.busy), 0);
    chk("async_rst_gnt", 32'(bus.gnt), 0);
    chk("async_rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("async_rst_adc_ch", 32'(bus.adc_ch), 0);
    obs_order.delete();
    plan_mode = 1;
    repeat (3) @(negedge clk_50M);
    rst_n = 1'b1;
    wait_rsp("post_reset_response", n_rsp + 1, 2000);
    chk("post_reset_first_gnt", 32'(order_at(0)), 0);
    drain("post_reset_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
